// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// States, header length and bytes-per-word used by imem_loader and byte_packer.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_HDR0,
    ST_HDR1,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } loader_state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/byte_packer.sv
// Byte-to-word packer: little-endian shift register with a 2-bit byte counter.
// Latency: word_vld pulses one cycle after the 4th byte; no backpressure, every byte_vld is taken.
// Backpressure: none; the caller gates byte_vld with its own handshake.
module byte_packer
  import imem_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  byte_vld,
  input  logic [7:0]            byte_dat,
  output logic                  last_byte,
  output logic                  word_vld,
  output logic [DATA_WIDTH-1:0] word_dat
);

  logic [1:0]            byte_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shifted;

  // New bytes enter at the top so the first byte ends up in bits [7:0].
  assign shifted   = {byte_dat, shreg[DATA_WIDTH-1:8]};
  assign last_byte = (byte_cnt == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      byte_cnt <= 2'd0;
      shreg    <= '0;
      word_vld <= 1'b0;
      word_dat <= '0;
    end else begin
      word_vld <= 1'b0;
      if (byte_vld) begin
        shreg    <= shifted;
        byte_cnt <= byte_cnt + 2'd1;
        if (last_byte) begin
          word_vld <= 1'b1;
          word_dat <= shifted;
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: byte stream (N header + 4*N payload bytes) -> imem writes; holds the core until done.
// Latency: each write one cycle after its 4th byte; in_ready low only in DONE/ERR. Optional IMEM_LOADER_CHECKSUM_EN adds a trailing sum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  restart,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  core_hold,
  output logic                  load_done,
  output logic                  load_err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam loader_state_t END_STATE = ST_CSUM;
  logic [7:0] csum;
`else
  localparam loader_state_t END_STATE = ST_DONE;
`endif

  loader_state_t state, next_state;
  logic          accept;
  logic          clear;
  logic          last_byte;
  logic          word_last;
  logic [7:0]    hdr_lo;
  logic [15:0]   hdr_n;
  logic [15:0]   n_words;
  logic [15:0]   word_cnt;

  assign accept    = in_valid && in_ready;
  assign clear     = restart && (state == ST_DONE || state == ST_ERR);
  assign hdr_n     = {in_data, hdr_lo};
  assign word_last = last_byte && (word_cnt == n_words - 16'd1);

  byte_packer #(.DATA_WIDTH(DATA_WIDTH)) u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .byte_vld  (accept && state == ST_DATA),
    .byte_dat  (in_data),
    .last_byte (last_byte),
    .word_vld  (mem_we),
    .word_dat  (mem_wdata)
  );

  always_comb begin
    next_state = state;
    case (state)
      ST_HDR0: if (accept) next_state = ST_HDR1;
      ST_HDR1: begin
        if (accept) begin
          if (32'(hdr_n) > DEPTH)   next_state = ST_ERR;
          else if (hdr_n == 16'd0)  next_state = END_STATE;
          else                      next_state = ST_DATA;
        end
      end
      ST_DATA: if (accept && word_last) next_state = END_STATE;
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CSUM: if (accept) next_state = (in_data == csum) ? ST_DONE : ST_ERR;
`endif
      ST_DONE, ST_ERR: if (restart) next_state = ST_HDR0;
      default: next_state = ST_HDR0;
    endcase
  end

  // Status outputs are registered from next_state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_HDR0;
      in_ready  <= 1'b1;
      core_hold <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      hdr_lo    <= 8'd0;
      n_words   <= 16'd0;
      word_cnt  <= 16'd0;
      mem_addr  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum      <= 8'd0;
`endif
    end else begin
      state     <= next_state;
      in_ready  <= (next_state != ST_DONE) && (next_state != ST_ERR);
      core_hold <= (next_state != ST_DONE);
      load_done <= (next_state == ST_DONE) && (state != ST_DONE);
      load_err  <= (next_state == ST_ERR);
      if (clear) begin
        hdr_lo   <= 8'd0;
        n_words  <= 16'd0;
        word_cnt <= 16'd0;
        mem_addr <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum     <= 8'd0;
`endif
      end else if (accept) begin
        case (state)
          ST_HDR0: hdr_lo  <= in_data;
          ST_HDR1: n_words <= hdr_n;
          ST_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum <= csum + in_data;
`endif
            if (last_byte) begin
              mem_addr <= ADDR_WIDTH'(word_cnt);
              word_cnt <= word_cnt + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: normal load, oversize header, empty image, mid-load reset, restart.
// Outputs are sampled 1 time unit after each rising edge.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        restart;
  logic        mem_we;
  logic [17:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        core_hold;
  logic        load_done;
  logic        load_err;

  typedef struct packed {
    logic        we;
    logic [17:0] addr;
    logic [31:0] wdata;
    logic        done;
    logic        err;
    logic        hold;
    logic        rdy;
  } obs_t;

  obs_t log_q[$];
  int   checks = 0;
  int   errors = 0;

  imem_loader dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .restart   (restart),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .core_hold (core_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive bytes back-to-back, logging outputs after each edge plus one idle cycle.
  task automatic run_stream(input logic [7:0] s[$]);
    obs_t o;
    log_q.delete();
    for (int i = 0; i <= s.size(); i++) begin
      in_valid = (i < s.size());
      in_data  = (i < s.size()) ? s[i] : 8'h00;
      @(posedge clk);
      #1;
      o = '{we: mem_we, addr: mem_addr, wdata: mem_wdata, done: load_done,
            err: load_err, hold: core_hold, rdy: in_ready};
      log_q.push_back(o);
    end
    in_valid = 1'b0;
  endtask

  function automatic int write_count();
    int n = 0;
    foreach (log_q[k]) if (log_q[k].we) n++;
    return n;
  endfunction

  task automatic pulse_restart();
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdy"},   32'(in_ready),  32'd1);
    check({tag, "_hold"},  32'(core_hold), 32'd1);
    check({tag, "_we"},    32'(mem_we),    32'd0);
    check({tag, "_addr"},  32'(mem_addr),  32'd0);
    check({tag, "_wdata"}, mem_wdata,      32'd0);
    check({tag, "_done"},  32'(load_done), 32'd0);
    check({tag, "_err"},   32'(load_err),  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s[$];
    int last;

    reset    = 1'b1;
    in_data  = 8'h00;
    in_valid = 1'b0;
    restart  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_outputs("rst");

    // Two-word image.
    s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    s.push_back(8'hB6);
`endif
    last = s.size() - 1;
    run_stream(s);
    check("img_nwrites", 32'(write_count()), 32'd2);
    check("img_w0_we",    32'(log_q[5].we),   32'd1);
    check("img_w0_addr",  32'(log_q[5].addr), 32'd0);
    check("img_w0_data",  log_q[5].wdata,     32'h0000_0013);
    check("img_w1_we",    32'(log_q[9].we),   32'd1);
    check("img_w1_addr",  32'(log_q[9].addr), 32'd1);
    check("img_w1_data",  log_q[9].wdata,     32'h0010_0093);
    check("img_hold_pre", 32'(log_q[last-1].hold), 32'd1);
    check("img_done",     32'(log_q[last].done),   32'd1);
    check("img_hold_end", 32'(log_q[last].hold),   32'd0);
    check("img_rdy_end",  32'(log_q[last].rdy),    32'd0);
    check("img_done_1cy", 32'(log_q[last+1].done), 32'd0);
    check("img_hold_aft", 32'(log_q[last+1].hold), 32'd0);

    // Restart together with a valid byte in DONE: byte must be dropped.
    in_valid = 1'b1;
    in_data  = 8'h55;
    pulse_restart();
    in_valid = 1'b0;
    check("rs_rdy",  32'(in_ready),  32'd1);
    check("rs_hold", 32'(core_hold), 32'd1);
    check("rs_done", 32'(load_done), 32'd0);

    // Empty image; would land in DATA if 0x55 above had been taken as N[7:0].
    s = '{8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    s.push_back(8'h00);
`endif
    last = s.size() - 1;
    run_stream(s);
    check("n0_nwrites", 32'(write_count()), 32'd0);
    check("n0_done",    32'(log_q[last].done), 32'd1);
    check("n0_hold",    32'(log_q[last].hold), 32'd0);
    pulse_restart();

    // N = 257 exceeds DEPTH.
    s = '{8'h01, 8'h01};
    run_stream(s);
    check("big_err",     32'(log_q[1].err),  32'd1);
    check("big_rdy",     32'(log_q[1].rdy),  32'd0);
    check("big_hold",    32'(log_q[1].hold), 32'd1);
    check("big_err_pre", 32'(log_q[0].err),  32'd0);
    check("big_err_hld", 32'(log_q[2].err),  32'd1);
    check("big_nwrites", 32'(write_count()), 32'd0);
    pulse_restart();
    check("big_rs_err", 32'(load_err), 32'd0);

    // Reset in the middle of the second word.
    s = '{8'h02, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    run_stream(s);
    check("mid_nwrites", 32'(write_count()), 32'd1);
    check("mid_w0_addr", 32'(log_q[5].addr), 32'd0);
    check("mid_w0_data", log_q[5].wdata,     32'hDDCC_BBAA);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_outputs("mid_rst");

    s = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
`ifdef IMEM_LOADER_CHECKSUM_EN
    s.push_back(8'h14);
`endif
    last = s.size() - 1;
    run_stream(s);
    check("fresh_nwrites", 32'(write_count()), 32'd1);
    check("fresh_addr",    32'(log_q[5].addr), 32'd0);
    check("fresh_data",    log_q[5].wdata,     32'h1234_5678);
    check("fresh_done",    32'(log_q[last].done), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    pulse_restart();
    s = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
    run_stream(s);
    check("cs_ok_done", 32'(log_q[6].done), 32'd1);
    check("cs_ok_data", log_q[5].wdata,     32'h0403_0201);
    pulse_restart();
    s = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0B};
    run_stream(s);
    check("cs_bad_err",  32'(log_q[6].err),  32'd1);
    check("cs_bad_hold", 32'(log_q[6].hold), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
